cp0_exc_unit: RTL

//  Parametrised CP0 / exception unit at the write-back stage of the 5-stage pipeline.

---
 rtl/cp0_exc_unit_pkg.sv | 33 +++
 rtl/cp0_timer.sv | 52 +++++
 rtl/cp0_exc_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions: register addresses {rd, sel}, exception codes and field positions.
package cp0_exc_unit_pkg;

   localparam logic [7:0] CP0_BADVADDR = 8'h40;  // 8.0
   localparam logic [7:0] CP0_COUNT    = 8'h48;  // 9.0
   localparam logic [7:0] CP0_COMPARE  = 8'h58;  // 11.0
   localparam logic [7:0] CP0_STATUS   = 8'h60;  // 12.0
   localparam logic [7:0] CP0_CAUSE    = 8'h68;  // 13.0
   localparam logic [7:0] CP0_EPC      = 8'h70;  // 14.0

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_SYS  = 5'd8,
      EXC_BP   = 5'd9,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   localparam int ST_IE       = 0;
   localparam int ST_EXL      = 1;
   localparam int ST_IM_LSB   = 8;
   localparam int CA_CODE_LSB = 2;
   localparam int CA_IP_LSB   = 8;
   localparam int CA_TI       = 30;
   localparam int CA_BD       = 31;

   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == EXC_ADEL) || (code == EXC_ADES);
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// COUNT/COMPARE timer: prescaled COUNT, COMPARE register and the sticky TI flag.
module cp0_timer #(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   localparam int                 DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(COUNT_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             div_tc;
   logic             match;

   assign div_tc = (div_cnt == DIV_LAST);
   assign match  = (count == compare) && (compare != 32'd0);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         div_cnt <= '0;
         count   <= 32'd0;
         compare <= 32'd0;
         ti      <= 1'b0;
      end else begin
         // A software write to COUNT restarts the prescaler from zero.
         if (count_we) begin
            count   <= wdata;
            div_cnt <= '0;
         end else if (div_tc) begin
            count   <= count + 32'd1;
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         if (compare_we) begin
            compare <= wdata;
            ti      <= 1'b0;
         end else if (match) begin
            ti      <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 / exception unit at write-back: CP0 registers, mfc0/mtc0, exception and
// interrupt entry, eret, and the redirect/cancel bus back to fetch.
module cp0_exc_unit
   import cp0_exc_unit_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0000,
   parameter int          HW_INT_NUM = 6,
   parameter int          COUNT_DIV  = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  wb_valid,
   input  logic [31:0]           wb_pc,
   input  logic                  wb_bd,
   input  logic                  mtc0,
   input  logic                  mfc0,
   input  logic [7:0]            cp0_addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   input  logic                  exc_req,
   input  logic [4:0]            exc_code,
   input  logic [31:0]           exc_badvaddr,
   input  logic                  eret,
   input  logic [HW_INT_NUM-1:0] hw_int,
   output logic                  exc_valid,
   output logic [31:0]           exc_target,
   output logic                  cancel,
   output logic                  commit_kill
);

   logic [7:0]            im;
   logic                  exl;
   logic                  ie;
   logic                  bd;
   logic [1:0]            ip_sw;
   logic [4:0]            exc_code_q;
   logic [HW_INT_NUM-1:0] hw_q;
   logic [31:0]           epc;
   logic [31:0]           badvaddr;
   logic [31:0]           count;
   logic [31:0]           compare;
   logic                  ti;

   logic [5:0]            hw_pad;
   logic [7:0]            ip;
   logic [31:0]           status_word;
   logic [31:0]           cause_word;

   logic                  int_take;
   logic                  exc_take;
   logic                  eret_take;
   logic                  mtc0_take;

   // With six external lines the top one shares IP[7] with the timer.
   always_comb begin
      hw_pad                  = '0;
      hw_pad[HW_INT_NUM-1:0]  = hw_q;
      ip                      = {hw_pad[5] | ti, hw_pad[4:0], ip_sw};
   end

   always_comb begin
      status_word                    = 32'd0;
      status_word[ST_IM_LSB +: 8]    = im;
      status_word[ST_EXL]            = exl;
      status_word[ST_IE]             = ie;
      cause_word                     = 32'd0;
      cause_word[CA_BD]              = bd;
      cause_word[CA_TI]              = ti;
      cause_word[CA_IP_LSB +: 8]     = ip;
      cause_word[CA_CODE_LSB +: 5]   = exc_code_q;
   end

   assign int_take  = wb_valid & ie & ~exl & (|(ip & im));
   assign exc_take  = int_take | (wb_valid & exc_req);
   assign eret_take = wb_valid & eret & ~exc_take;
   assign mtc0_take = wb_valid & mtc0 & ~exc_take & ~eret;

   assign exc_valid   = resetn & (exc_take | eret_take);
   assign cancel      = exc_valid;
   assign commit_kill = resetn & exc_take;
   assign exc_target  = eret_take ? epc : EXC_VECTOR;

   always_comb begin
      rdata = 32'd0;
      if (resetn && wb_valid && mfc0) begin
         case (cp0_addr)
            CP0_STATUS:   rdata = status_word;
            CP0_CAUSE:    rdata = cause_word;
            CP0_EPC:      rdata = epc;
            CP0_BADVADDR: rdata = badvaddr;
            CP0_COUNT:    rdata = count;
            CP0_COMPARE:  rdata = compare;
            default:      rdata = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         im         <= 8'd0;
         exl        <= 1'b0;
         ie         <= 1'b0;
         bd         <= 1'b0;
         ip_sw      <= 2'd0;
         exc_code_q <= 5'd0;
         hw_q       <= '0;
         epc        <= 32'd0;
         badvaddr   <= 32'd0;
      end else begin
         hw_q <= hw_int;
         if (exc_take) begin
            exl <= 1'b1;
            // A nested exception keeps the return point of the outer one.
            if (!exl) begin
               bd  <= wb_bd;
               epc <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
            end
            exc_code_q <= int_take ? EXC_INT : exc_code;
            if (!int_take && is_addr_exc(exc_code))
               badvaddr <= exc_badvaddr;
         end else if (eret_take) begin
            exl <= 1'b0;
         end else if (mtc0_take) begin
            case (cp0_addr)
               CP0_STATUS: begin
                  im  <= wdata[ST_IM_LSB +: 8];
                  exl <= wdata[ST_EXL];
                  ie  <= wdata[ST_IE];
               end
               CP0_CAUSE:    ip_sw    <= wdata[CA_IP_LSB +: 2];
               CP0_EPC:      epc      <= wdata;
               CP0_BADVADDR: badvaddr <= wdata;
               default: ;
            endcase
         end
      end
   end

   cp0_timer #(
      .COUNT_DIV (COUNT_DIV)
   ) u_timer (
      .clk        (clk),
      .resetn     (resetn),
      .count_we   (mtc0_take && (cp0_addr == CP0_COUNT)),
      .compare_we (mtc0_take && (cp0_addr == CP0_COMPARE)),
      .wdata      (wdata),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

endmodule
